// File: rtl/seq_pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector_pkg
// Description : Shared constants, types and helpers for the parametrised
//               symbol-stream sequence detector.
//                 - default pattern ("state"), symbol width, counter width
//                 - overlap-mode encoding
//                 - width helper for the match-length output
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pattern_detector_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PAT_LEN = 5;
  localparam int DEF_CNT_W   = 16;

  // First symbol occupies the MSBs, matching Verilog string ordering.
  localparam logic [DEF_PAT_LEN*DEF_DATA_W-1:0] DEF_PATTERN = "state";

  // Behaviour of the history once a full match completes.
  typedef enum logic [0:0] {
    MODE_RESTART = 1'b0,   // drop history, next symbol starts a fresh search
    MODE_OVERLAP = 1'b1    // keep history, later matches may reuse its tail
  } ovl_mode_e;

  // Bits needed to hold a value in 0..n inclusive.
  function automatic int len_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : seq_pattern_detector_pkg
`default_nettype wire

// File: rtl/seq_pattern_detector_prefix_cmp.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector_prefix_cmp
// Description : Combinational prefix comparator. For every candidate length
//               k = 1..PAT_LEN it decides whether the newest k-1 history
//               symbols followed by the incoming symbol equal the first k
//               symbols of PATTERN.
// Ports       :
//   i_hist      in  (PAT_LEN-1)*DATA_W  history, entry 0 (LSBs) is newest
//   i_hist_cnt  in  HCNT_W              number of valid history entries
//   i_din       in  DATA_W              incoming symbol
//   o_cand      out PAT_LEN             bit k-1 set when candidate k holds
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector_prefix_cmp #(
  parameter int                          DATA_W  = 8,
  parameter int                          PAT_LEN = 5,
  parameter logic [PAT_LEN*DATA_W-1:0]   PATTERN = '0,
  parameter int                          HCNT_W  = $clog2(PAT_LEN)
) (
  input  logic [(PAT_LEN-1)*DATA_W-1:0]  i_hist,
  input  logic [HCNT_W-1:0]              i_hist_cnt,
  input  logic [DATA_W-1:0]              i_din,
  output logic [PAT_LEN-1:0]             o_cand
);

  for (genvar k = 1; k <= PAT_LEN; k++) begin : g_cand
    // w_eq[k-1]: incoming symbol vs pattern symbol k-1
    // w_eq[m]  : history entry (k-2-m) vs pattern symbol m, m < k-1
    logic [k-1:0] w_eq;

    assign w_eq[k-1] = (i_din == PATTERN[(PAT_LEN-k)*DATA_W +: DATA_W]);

    for (genvar m = 0; m < k - 1; m++) begin : g_hist
      assign w_eq[m] = (i_hist[(k-2-m)*DATA_W +: DATA_W] ==
                        PATTERN[(PAT_LEN-1-m)*DATA_W +: DATA_W]);
    end

    // Entries beyond hist_cnt are stale (e.g. after a non-overlapping match)
    // and must not contribute to a prefix.
    assign o_cand[k-1] = (HCNT_W'(k-1) <= i_hist_cnt) && (&w_eq);
  end

endmodule : seq_pattern_detector_prefix_cmp
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector
// Description : Parametrised symbol-stream sequence detector. Tracks the
//               longest pattern prefix that is a suffix of the accepted
//               stream, pulses o_match for one cycle on a full match and
//               counts matches in a saturating counter.
// Ports       :
//   clk          in  1        system clock, rising edge
//   rst          in  1        asynchronous reset, active-high
//   i_clr        in  1        synchronous clear of progress/history/counter
//   i_din_valid  in  1        i_din accepted this cycle when high
//   i_din        in  DATA_W   input symbol
//   i_overlap_en in  1        1: matches may share symbols
//   o_match      out 1        one-cycle match pulse (registered)
//   o_match_len  out LEN_W    pattern symbols currently matched
//   o_match_cnt  out CNT_W    matches since reset/clear, saturating
//   o_cnt_ovf    out 1        sticky: match arrived with counter saturated
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int                          DATA_W  = DEF_DATA_W,
  parameter int                          PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN*DATA_W-1:0]   PATTERN = DEF_PATTERN,
  parameter int                          CNT_W   = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clr,
  input  logic                           i_din_valid,
  input  logic [DATA_W-1:0]              i_din,
  input  logic                           i_overlap_en,
  output logic                           o_match,
  output logic [len_w(PAT_LEN)-1:0]      o_match_len,
  output logic [CNT_W-1:0]               o_match_cnt,
  output logic                           o_cnt_ovf
);

  localparam int LEN_W  = len_w(PAT_LEN);
  localparam int HCNT_W = $clog2(PAT_LEN);

  if (PAT_LEN < 2) begin : g_bad_pat_len
    $error("seq_pattern_detector: PAT_LEN must be at least 2");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PAT_LEN-2:0][DATA_W-1:0] r_hist;       // entry 0 is the newest symbol
  logic [HCNT_W-1:0]              r_hist_cnt;
  logic                           r_match;
  logic [LEN_W-1:0]               r_match_len;
  logic [CNT_W-1:0]               r_match_cnt;
  logic                           r_cnt_ovf;

  // --------------------------------------------------------------------------
  // Candidate evaluation and priority encode
  // --------------------------------------------------------------------------
  logic [PAT_LEN-1:0] w_cand;
  logic [LEN_W-1:0]   w_kmax;
  logic               w_full;
  logic               w_accept;
  ovl_mode_e          w_mode;

  seq_pattern_detector_prefix_cmp #(
    .DATA_W  (DATA_W),
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .HCNT_W  (HCNT_W)
  ) u_prefix_cmp (
    .i_hist     (r_hist),
    .i_hist_cnt (r_hist_cnt),
    .i_din      (i_din),
    .o_cand     (w_cand)
  );

  // Longest true candidate wins; a mismatch can therefore fall back to a
  // shorter prefix instead of restarting from zero.
  always_comb begin
    w_kmax = '0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (w_cand[k-1]) begin
        w_kmax = LEN_W'(k);
      end
    end
  end

  assign w_full   = w_cand[PAT_LEN-1];
  assign w_accept = i_din_valid && !i_clr;
  assign w_mode   = ovl_mode_e'(i_overlap_en);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist      <= '0;
      r_hist_cnt  <= '0;
      r_match     <= 1'b0;
      r_match_len <= '0;
      r_match_cnt <= '0;
      r_cnt_ovf   <= 1'b0;
    end else if (i_clr) begin
      // Clear takes priority over a simultaneous valid symbol, which is dropped.
      r_hist      <= '0;
      r_hist_cnt  <= '0;
      r_match     <= 1'b0;
      r_match_len <= '0;
      r_match_cnt <= '0;
      r_cnt_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_match     <= w_full;
      r_match_len <= w_kmax;

      for (int i = PAT_LEN - 2; i > 0; i--) begin
        r_hist[i] <= r_hist[i-1];
      end
      r_hist[0] <= i_din;

      if (w_full && (w_mode == MODE_RESTART)) begin
        r_hist_cnt <= '0;
      end else if (r_hist_cnt != HCNT_W'(PAT_LEN - 1)) begin
        r_hist_cnt <= r_hist_cnt + HCNT_W'(1);
      end

      if (w_full) begin
        if (&r_match_cnt) begin
          r_cnt_ovf <= 1'b1;
        end else begin
          r_match_cnt <= r_match_cnt + CNT_W'(1);
        end
      end
    end else begin
      // Idle cycle: progress is held, only the pulse is retired.
      r_match <= 1'b0;
    end
  end

  assign o_match     = r_match;
  assign o_match_len = r_match_len;
  assign o_match_cnt = r_match_cnt;
  assign o_cnt_ovf   = r_cnt_ovf;

endmodule : seq_pattern_detector
`default_nettype wire
